// File: rtl/bus_wr_arbiter_if.sv
// Write-bus bundle for bus_wr_arbiter: two master request channels plus the
// registered slave-side channel. The arbiter connects through the slave modport.
interface bus_wr_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 9
);
  logic [AW-1:0] m0_wraddr;
  logic [DW-1:0] m0_wrdata;
  logic          m0_wrvalid;
  logic          m0_wrlock;
  logic          m0_wrready;

  logic [AW-1:0] m1_wraddr;
  logic [DW-1:0] m1_wrdata;
  logic          m1_wrvalid;
  logic          m1_wrlock;
  logic          m1_wrready;

  logic [AW-1:0] bus_wraddr;
  logic [DW-1:0] bus_wrdata;
  logic          bus_wrvalid;
  logic          bus_wrready;
  logic          bus_owner;

  modport slave (
    input  m0_wraddr, m0_wrdata, m0_wrvalid, m0_wrlock,
    input  m1_wraddr, m1_wrdata, m1_wrvalid, m1_wrlock,
    output m0_wrready, m1_wrready,
    output bus_wraddr, bus_wrdata, bus_wrvalid, bus_owner,
    input  bus_wrready
  );

  modport master (
    output m0_wraddr, m0_wrdata, m0_wrvalid, m0_wrlock,
    output m1_wraddr, m1_wrdata, m1_wrvalid, m1_wrlock,
    input  m0_wrready, m1_wrready,
    input  bus_wraddr, bus_wrdata, bus_wrvalid, bus_owner,
    output bus_wrready
  );
endinterface

// File: rtl/bus_wr_arbiter.sv
// Two-master write-bus arbiter: round-robin with a bounded burst lock, feeding
// a one-entry registered output stage that sits directly in front of the slave.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_EMPTY | output stage holds no beat, bus_wrvalid=0
//   ST_FULL  | output stage holds a beat for the slave, bus_wrvalid=1
module bus_wr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int AW        = 17,
  parameter int DW        = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_wr_arbiter_if.slave  bif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          locked_q, locked_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          owner_q, owner_d;

  logic hold;
  logic win;
  logic load;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    locked_d    = locked_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    owner_d     = owner_q;

    // The lock owner is always `last`, since locked is taken from the last beat.
    hold = locked_q && (burst_cnt_q < BURST_LIM);
    if (bif.m0_wrvalid && bif.m1_wrvalid) begin
      win = hold ? last_q : ~last_q;
    end else begin
      win = bif.m1_wrvalid;
    end
    load = (bif.m0_wrvalid || bif.m1_wrvalid) &&
           ((state_q == ST_EMPTY) || bif.bus_wrready);

    if (load) begin
      state_d  = ST_FULL;
      owner_d  = win;
      last_d   = win;
      addr_d   = win ? bif.m1_wraddr : bif.m0_wraddr;
      data_d   = win ? bif.m1_wrdata : bif.m0_wrdata;
      locked_d = win ? bif.m1_wrlock : bif.m0_wrlock;
      if ((win == last_q) && locked_q) begin
        burst_cnt_d = (burst_cnt_q == 4'hF) ? burst_cnt_q : burst_cnt_q + 4'd1;
      end else begin
        burst_cnt_d = 4'd0;
      end
    end else begin
      if ((state_q == ST_FULL) && bif.bus_wrready) begin
        state_d = ST_EMPTY;
      end
      // Lock lapses once its owner stops presenting beats.
      if (locked_q && !(last_q ? bif.m1_wrvalid : bif.m0_wrvalid)) begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      last_q      <= 1'b1;
      locked_q    <= 1'b0;
      burst_cnt_q <= 4'd0;
      addr_q      <= '0;
      data_q      <= '0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      locked_q    <= locked_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      owner_q     <= owner_d;
    end
  end

  assign bif.m0_wrready  = rst_n & load & ~win;
  assign bif.m1_wrready  = rst_n & load & win;
  assign bif.bus_wraddr  = addr_q;
  assign bif.bus_wrdata  = data_q;
  assign bif.bus_wrvalid = (state_q == ST_FULL);
  assign bif.bus_owner   = owner_q;

endmodule

// File: tb/tb_bus_wr_arbiter.sv
// Self-checking bench for bus_wr_arbiter: directed scenarios plus a randomized
// run against a rule-level arbitration model and per-master ordering scoreboard.
module tb_bus_wr_arbiter;
  localparam int AW = 17;
  localparam int DW = 9;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bus_wr_arbiter_if #(.AW(AW), .DW(DW)) bif ();

  bus_wr_arbiter #(.MAX_BURST(MAX_BURST), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  // master-side stimulus
  int            seq [2];
  bit            act [2];
  bit            lck [2];
  bit            acc [2];
  logic [AW-1:0] cur_a [2];
  logic [DW-1:0] cur_d [2];
  bit            rdy;
  beat_t         sb0 [$];
  beat_t         sb1 [$];

  // reference model: arbitration history and contents of the output stage
  bit            m_last;
  bit            m_locked;
  int            m_streak;
  bit            m_full;
  bit            m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  bit            cons_v;
  bit            cons_owner;
  logic [AW-1:0] cons_addr;
  logic [DW-1:0] cons_data;

  function automatic logic [AW-1:0] beat_addr(input int x, input int s);
    logic [AW-1:0] r;
    r = AW'(s * 3);
    r[AW-1] = (x != 0);
    return r;
  endfunction

  function automatic logic [DW-1:0] beat_data(input int x, input int s);
    return DW'(s * 37 + x * 101 + 5);
  endfunction

  task automatic set_next(input int x);
    seq[x]++;
    cur_a[x] = beat_addr(x, seq[x]);
    cur_d[x] = beat_data(x, seq[x]);
  endtask

  task automatic drive();
    bif.m0_wraddr   = cur_a[0];
    bif.m0_wrdata   = cur_d[0];
    bif.m0_wrvalid  = act[0];
    bif.m0_wrlock   = lck[0];
    bif.m1_wraddr   = cur_a[1];
    bif.m1_wrdata   = cur_d[1];
    bif.m1_wrvalid  = act[1];
    bif.m1_wrlock   = lck[1];
    bif.bus_wrready = rdy;
    #1;
  endtask

  task automatic model_reset();
    m_last = 1'b1; m_locked = 1'b0; m_streak = 0;
    m_full = 1'b0; m_owner = 1'b0; m_addr = '0; m_data = '0;
    sb0.delete(); sb1.delete();
  endtask

  // Only one requester: it wins. Both: the previous winner keeps the bus only
  // while its lock is live and it has had fewer than MAX_BURST beats in a row.
  function automatic void model_pick(output bit ld, output bit w);
    bit keep;
    keep = m_locked && (m_streak + 1 < MAX_BURST);
    ld = (act[0] || act[1]) && (!m_full || rdy);
    if (act[0] && act[1]) w = keep ? m_last : !m_last;
    else w = act[1];
  endfunction

  // Advances one clock: model update, scoreboard push, master advance.
  task automatic tick();
    bit ld, w;
    model_pick(ld, w);
    cons_v     = bif.bus_wrvalid && rdy;
    cons_owner = bif.bus_owner;
    cons_addr  = bif.bus_wraddr;
    cons_data  = bif.bus_wrdata;
    acc[0] = bif.m0_wrready;
    acc[1] = bif.m1_wrready;
    if (acc[0]) sb0.push_back('{a: cur_a[0], d: cur_d[0]});
    if (acc[1]) sb1.push_back('{a: cur_a[1], d: cur_d[1]});
    @(posedge clk);
    if (ld) begin
      if (w == m_last && m_locked) m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
      else m_streak = 0;
      m_last = w; m_locked = lck[w];
      m_full = 1'b1; m_owner = w; m_addr = cur_a[w]; m_data = cur_d[w];
    end else begin
      if (m_full && rdy) m_full = 1'b0;
      if (m_locked && !act[m_last]) m_locked = 1'b0;
    end
    for (int x = 0; x < 2; x++) if (acc[x]) set_next(x);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    act[0] = 0; act[1] = 0; lck[0] = 0; lck[1] = 0; rdy = 1'b1;
    drive();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    act[0] = 1; act[1] = 1; lck[0] = 0; lck[1] = 0; rdy = 1'b1;
    @(negedge clk);
    drive();
    n_checks++;
    if (bif.bus_wrvalid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bif.bus_wrvalid); else n_pass++;
    n_checks++;
    if (bif.bus_wraddr !== '0 || bif.bus_wrdata !== '0)
      $display("FAIL reset_addr_data: got %h/%h want 0/0", bif.bus_wraddr, bif.bus_wrdata);
    else n_pass++;
    n_checks++;
    if (bif.bus_owner !== 1'b0) $display("FAIL reset_owner: got %b want 0", bif.bus_owner); else n_pass++;
    n_checks++;
    if ({bif.m0_wrready, bif.m1_wrready} !== 2'b00)
      $display("FAIL reset_ready: got %b%b want 00", bif.m0_wrready, bif.m1_wrready);
    else n_pass++;
    act[0] = 0; act[1] = 0;
    drive();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    cur_a[0] = 17'h00100; cur_d[0] = 9'h1A5;
    act[0] = 1; act[1] = 0; lck[0] = 0; rdy = 1'b1;
    drive();
    n_checks++;
    if ({bif.m0_wrready, bif.m1_wrready} !== 2'b10)
      $display("FAIL single_ready: got %b%b want 10", bif.m0_wrready, bif.m1_wrready);
    else n_pass++;
    tick();
    act[0] = 0;
    drive();
    n_checks++;
    if (bif.bus_wrvalid !== 1'b1 || bif.bus_wraddr !== 17'h00100 || bif.bus_wrdata !== 9'h1A5 || bif.bus_owner !== 1'b0)
      $display("FAIL single_beat: got v=%b %h/%h own=%b want v=1 00100/1a5 own=0",
               bif.bus_wrvalid, bif.bus_wraddr, bif.bus_wrdata, bif.bus_owner);
    else n_pass++;
    tick();
    n_checks++;
    if (bif.bus_wrvalid !== 1'b0) $display("FAIL single_drain: got %b want 0", bif.bus_wrvalid); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ea;
    apply_reset();
    act[0] = 1; act[1] = 1;
    for (int k = 0; k < 8; k++) begin
      drive();
      n_checks++;
      if (bif.m0_wrready !== (k % 2 == 0) || bif.m1_wrready !== (k % 2 == 1))
        $display("FAIL rr_ready[%0d]: got %b%b want m%0d", k, bif.m0_wrready, bif.m1_wrready, k % 2);
      else n_pass++;
      ea = cur_a[k % 2];
      tick();
      n_checks++;
      if (bif.bus_wrvalid !== 1'b1 || bif.bus_owner !== 1'(k % 2) || bif.bus_wraddr !== ea)
        $display("FAIL rr_bus[%0d]: got v=%b own=%b addr=%h want v=1 own=%0d addr=%h",
                 k, bif.bus_wrvalid, bif.bus_owner, bif.bus_wraddr, k % 2, ea);
      else n_pass++;
    end
  endtask

  task automatic test_lock_burst();
    int w, run, max_run;
    apply_reset();
    act[0] = 0; act[1] = 1; lck[1] = 1;
    run = 0; max_run = 0;
    for (int k = 0; k < 15; k++) begin
      w = (k % 5 == 4) ? 0 : 1;
      drive();
      n_checks++;
      if (bif.m0_wrready !== (w == 0) || bif.m1_wrready !== (w == 1))
        $display("FAIL lock_ready[%0d]: got %b%b want m%0d", k, bif.m0_wrready, bif.m1_wrready, w);
      else n_pass++;
      tick();
      n_checks++;
      if (bif.bus_owner !== 1'(w)) $display("FAIL lock_owner[%0d]: got %b want %0d", k, bif.bus_owner, w);
      else n_pass++;
      run = (bif.bus_owner === 1'b1) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      act[0] = 1;
    end
    n_checks++;
    if (max_run > MAX_BURST) $display("FAIL lock_max_run: got %0d want <= %0d", max_run, MAX_BURST);
    else n_pass++;
    lck[1] = 0;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    apply_reset();
    act[0] = 1; act[1] = 1;
    drive();
    ha = cur_a[0]; hd = cur_d[0];
    tick();
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive();
      n_checks++;
      if ({bif.m0_wrready, bif.m1_wrready} !== 2'b00)
        $display("FAIL bp_ready[%0d]: got %b%b want 00", k, bif.m0_wrready, bif.m1_wrready);
      else n_pass++;
      tick();
      n_checks++;
      if (bif.bus_wrvalid !== 1'b1 || bif.bus_wraddr !== ha || bif.bus_wrdata !== hd)
        $display("FAIL bp_hold[%0d]: got v=%b %h/%h want v=1 %h/%h", k, bif.bus_wrvalid, bif.bus_wraddr, bif.bus_wrdata, ha, hd);
      else n_pass++;
    end
    rdy = 1'b1;
    drive();
    n_checks++;
    if ({bif.m0_wrready, bif.m1_wrready} !== 2'b01)
      $display("FAIL bp_release_ready: got %b%b want 01", bif.m0_wrready, bif.m1_wrready);
    else n_pass++;
    ha = cur_a[1];
    tick();
    n_checks++;
    if (bif.bus_wrvalid !== 1'b1 || bif.bus_owner !== 1'b1 || bif.bus_wraddr !== ha)
      $display("FAIL bp_release_beat: got v=%b own=%b %h want v=1 own=1 %h", bif.bus_wrvalid, bif.bus_owner, bif.bus_wraddr, ha);
    else n_pass++;
  endtask

  task automatic test_solo_lock();
    int n_acc;
    apply_reset();
    act[0] = 1; lck[0] = 1; act[1] = 0;
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      drive();
      if (bif.m0_wrready === 1'b1) n_acc++;
      tick();
    end
    n_checks++;
    if (n_acc != 20) $display("FAIL solo_accepts: got %0d want 20", n_acc); else n_pass++;
    act[1] = 1;
    drive();
    n_checks++;
    if ({bif.m0_wrready, bif.m1_wrready} !== 2'b01)
      $display("FAIL solo_contest: got %b%b want 01", bif.m0_wrready, bif.m1_wrready);
    else n_pass++;
    tick();
    n_checks++;
    if (bif.bus_owner !== 1'b1) $display("FAIL solo_contest_owner: got %b want 1", bif.bus_owner); else n_pass++;
    lck[0] = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    act[0] = 0; act[1] = 1;
    drive();
    tick();
    act[0] = 1;
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bif.bus_wrvalid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bif.bus_wrvalid); else n_pass++;
    n_checks++;
    if ({bif.m0_wrready, bif.m1_wrready} !== 2'b00)
      $display("FAIL rstmid_ready: got %b%b want 00", bif.m0_wrready, bif.m1_wrready);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive();
    n_checks++;
    if ({bif.m0_wrready, bif.m1_wrready} !== 2'b10)
      $display("FAIL rstmid_first: got %b%b want 10", bif.m0_wrready, bif.m1_wrready);
    else n_pass++;
    tick();
    n_checks++;
    if (bif.bus_owner !== 1'b0 || bif.bus_wrvalid !== 1'b1)
      $display("FAIL rstmid_owner: got own=%b v=%b want own=0 v=1", bif.bus_owner, bif.bus_wrvalid);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ld, w;
    beat_t b;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (!act[x] || acc[x]) begin
          act[x] = ($urandom_range(0, 99) < 65);
          lck[x] = ($urandom_range(0, 1) == 1);
        end
      end
      rdy = ($urandom_range(0, 99) < 70);
      drive();
      model_pick(ld, w);
      n_checks++;
      if (bif.m0_wrready !== (ld && !w) || bif.m1_wrready !== (ld && w))
        $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, bif.m0_wrready, bif.m1_wrready, ld && !w, ld && w);
      else n_pass++;
      tick();
      n_checks++;
      if (bif.bus_wrvalid !== m_full ||
          (m_full && (bif.bus_owner !== m_owner || bif.bus_wraddr !== m_addr || bif.bus_wrdata !== m_data)))
        $display("FAIL rnd_bus[%0d]: got v=%b own=%b %h/%h want v=%b own=%b %h/%h", c,
                 bif.bus_wrvalid, bif.bus_owner, bif.bus_wraddr, bif.bus_wrdata, m_full, m_owner, m_addr, m_data);
      else n_pass++;
      if (cons_v) begin
        n_checks++;
        if ((cons_owner ? sb1.size() : sb0.size()) == 0) begin
          $display("FAIL rnd_order[%0d]: got beat %h from m%0d want none pending", c, cons_addr, cons_owner);
        end else begin
          b = cons_owner ? sb1.pop_front() : sb0.pop_front();
          if (b.a !== cons_addr || b.d !== cons_data)
            $display("FAIL rnd_order[%0d]: got %h/%h want %h/%h", c, cons_addr, cons_data, b.a, b.d);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    for (int x = 0; x < 2; x++) begin
      seq[x] = 0; acc[x] = 0;
      cur_a[x] = beat_addr(x, 0); cur_d[x] = beat_data(x, 0);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_lock_burst();
    test_backpressure();
    test_solo_lock();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
